msrv32_store_buffer: RTL and testbench

//  Posted-write buffer between the store unit and the AHB-lite data bus.
//  - Captures the store unit's word-aligned address, lane-aligned data and byte-lane mask.
//  - Queues them in a FIFO and drains them to memory as single AHB-lite write transfers.
//  - Stalls the pipeline only when the buffer is full.

---
 rtl/msrv32_store_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_msrv32_store_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_store_buffer.sv
// Posted-write buffer: queues store-unit writes and drains them as single AHB-lite write transfers.
// Optional feature macro SB_LOAD_HAZARD_EN enables the queued-store load hazard check.
module msrv32_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        st_req_in,
  input  logic [31:0] st_addr_in,
  input  logic [31:0] st_data_in,
  input  logic [3:0]  st_mask_in,
  output logic        st_stall_out,
  output logic        sb_empty_out,
  output logic        sb_err_out,
  output logic [31:0] ahb_haddr_out,
  output logic [1:0]  ahb_htrans_out,
  output logic        ahb_hwrite_out,
  output logic [2:0]  ahb_hsize_out,
  output logic [31:0] ahb_hwdata_out,
  output logic [3:0]  ahb_hwstrb_out,
  input  logic        ahb_hready_in,
  input  logic        ahb_hresp_in,
  input  logic [31:0] ld_addr_in,
  output logic        ld_hazard_out
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [29:0] addr_mem_q [DEPTH];
  logic [29:0] addr_mem_d [DEPTH];
  logic [31:0] data_mem_q [DEPTH];
  logic [31:0] data_mem_d [DEPTH];
  logic [3:0]  mask_mem_q [DEPTH];
  logic [3:0]  mask_mem_d [DEPTH];

  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [3:0]  hwstrb_q, hwstrb_d;
  logic        sb_err_q, sb_err_d;

  logic          full, empty, push, pop;
  logic [AW:0]   count;
  logic [AW-1:0] head_idx, next_idx;
  logic          unused_ok;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign push     = st_req_in && !full && (st_mask_in != 4'b0000);
  assign pop      = (state_q == S_DATA) && ahb_hready_in;
  assign head_idx = rd_ptr_q[AW-1:0];
  assign next_idx = head_idx + 1'b1;
  assign unused_ok = ^{ld_addr_in, st_addr_in[1:0]};

  function automatic logic [1:0] low_lane(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [2:0] size_of(input logic [3:0] m);
    logic [2:0] n;
    n = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    case (n)
      3'd1:    return 3'b000;
      3'd2:    return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    mask_mem_d = mask_mem_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hwdata_d   = hwdata_q;
    hwstrb_d   = hwstrb_q;
    sb_err_d   = sb_err_q;

    if (push) begin
      addr_mem_d[wr_ptr_q[AW-1:0]] = st_addr_in[31:2];
      data_mem_d[wr_ptr_q[AW-1:0]] = st_data_in;
      mask_mem_d[wr_ptr_q[AW-1:0]] = st_mask_in;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    // Address-phase outputs are registered on entry to ADDR from whichever entry will be the head.
    case (state_q)
      S_IDLE: begin
        htrans_d = 2'b00;
        hwrite_d = 1'b0;
        if (!empty) begin
          state_d  = S_ADDR;
          haddr_d  = {addr_mem_q[head_idx], low_lane(mask_mem_q[head_idx])};
          hsize_d  = size_of(mask_mem_q[head_idx]);
          htrans_d = 2'b10;
          hwrite_d = 1'b1;
        end
      end
      S_ADDR: begin
        if (ahb_hready_in) begin
          state_d  = S_DATA;
          htrans_d = 2'b00;
          hwrite_d = 1'b0;
          hwdata_d = data_mem_q[head_idx];
          hwstrb_d = mask_mem_q[head_idx];
        end
      end
      S_DATA: begin
        if (ahb_hready_in) begin
          if (ahb_hresp_in) sb_err_d = 1'b1;
          if (count > (AW+1)'(1)) begin
            state_d  = S_ADDR;
            haddr_d  = {addr_mem_q[next_idx], low_lane(mask_mem_q[next_idx])};
            hsize_d  = size_of(mask_mem_q[next_idx]);
            htrans_d = 2'b10;
            hwrite_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
        mask_mem_q[i] <= '0;
      end
      haddr_q  <= '0;
      htrans_q <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      hwdata_q <= '0;
      hwstrb_q <= '0;
      sb_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
      mask_mem_q <= mask_mem_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hwdata_q   <= hwdata_d;
      hwstrb_q   <= hwstrb_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign st_stall_out   = full;
  assign sb_empty_out   = empty && (state_q == S_IDLE);
  assign sb_err_out     = sb_err_q;
  assign ahb_haddr_out  = haddr_q;
  assign ahb_htrans_out = htrans_q;
  assign ahb_hwrite_out = hwrite_q;
  assign ahb_hsize_out  = hsize_q;
  assign ahb_hwdata_out = hwdata_q;
  assign ahb_hwstrb_out = hwstrb_q;

`ifdef SB_LOAD_HAZARD_EN
  logic [AW-1:0] off;
  // An entry is valid while its distance from the head is below the occupancy, in-flight head included.
  always_comb begin
    ld_hazard_out = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head_idx;
      if (({1'b0, off} < count) && (addr_mem_q[i] == ld_addr_in[31:2])) ld_hazard_out = 1'b1;
    end
  end
`else
  assign ld_hazard_out = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_store_buffer.sv
// Directed self-checking bench for msrv32_store_buffer.
module tb_msrv32_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_req;
  logic [31:0] st_addr, st_data;
  logic [3:0]  st_mask;
  logic        st_stall, sb_empty, sb_err;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hwstrb;
  logic        hready, hresp;
  logic [31:0] ld_addr;
  logic        ld_hazard;

  int checks = 0;
  int errors = 0;

`ifdef SB_LOAD_HAZARD_EN
  localparam logic HAZ_EXP = 1'b1;
`else
  localparam logic HAZ_EXP = 1'b0;
`endif

  msrv32_store_buffer dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .st_req_in(st_req),
    .st_addr_in(st_addr),
    .st_data_in(st_data),
    .st_mask_in(st_mask),
    .st_stall_out(st_stall),
    .sb_empty_out(sb_empty),
    .sb_err_out(sb_err),
    .ahb_haddr_out(haddr),
    .ahb_htrans_out(htrans),
    .ahb_hwrite_out(hwrite),
    .ahb_hsize_out(hsize),
    .ahb_hwdata_out(hwdata),
    .ahb_hwstrb_out(hwstrb),
    .ahb_hready_in(hready),
    .ahb_hresp_in(hresp),
    .ld_addr_in(ld_addr),
    .ld_hazard_out(ld_hazard)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enqueue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    st_req = 1'b1; st_addr = a; st_data = d; st_mask = m;
    step();
    st_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; st_req = 1'b0; st_addr = '0; st_data = '0; st_mask = '0;
    hready = 1'b1; hresp = 1'b0; ld_addr = '0;
    step(); step();
    rst = 1'b0;
    checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL reset_htrans got=%h exp=0", htrans); end
    checks++; if (haddr !== 32'h0) begin errors++; $display("FAIL reset_haddr got=%h exp=0", haddr); end
    checks++; if ({hwrite, hsize, hwstrb} !== 8'h00) begin errors++; $display("FAIL reset_ctl got=%b%b%b exp=0", hwrite, hsize, hwstrb); end
    checks++; if (hwdata !== 32'h0) begin errors++; $display("FAIL reset_hwdata got=%h exp=0", hwdata); end
    checks++; if ({st_stall, sb_empty, sb_err, ld_hazard} !== 4'b0100) begin errors++; $display("FAIL reset_status got=%b exp=0100", {st_stall, sb_empty, sb_err, ld_hazard}); end
  endtask

  task automatic test_mask_zero();
    enqueue(32'h0000_0080, 32'h1234_5678, 4'b0000);
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL mask0_empty got=%b exp=1", sb_empty); end
    step(); step();
    checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL mask0_htrans got=%h exp=0", htrans); end
  endtask

  task automatic test_single_byte();
    enqueue(32'h0000_0100, 32'h0000_00AB, 4'b0001);
    checks++; if ({sb_empty, htrans} !== 3'b000) begin errors++; $display("FAIL t1_queued got=%b exp=000", {sb_empty, htrans}); end
    step();
    checks++; if ({htrans, hwrite} !== 3'b101) begin errors++; $display("FAIL t1_addr_ctl got=%b exp=101", {htrans, hwrite}); end
    checks++; if (haddr !== 32'h0000_0100) begin errors++; $display("FAIL t1_haddr got=%h exp=100", haddr); end
    checks++; if (hsize !== 3'b000) begin errors++; $display("FAIL t1_hsize got=%b exp=000", hsize); end
    step();
    checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL t1_data_htrans got=%h exp=0", htrans); end
    checks++; if (hwdata !== 32'h0000_00AB) begin errors++; $display("FAIL t1_hwdata got=%h exp=ab", hwdata); end
    checks++; if (hwstrb !== 4'b0001) begin errors++; $display("FAIL t1_hwstrb got=%b exp=0001", hwstrb); end
    step();
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL t1_empty got=%b exp=1", sb_empty); end
  endtask

  task automatic test_halfword();
    enqueue(32'h0000_0204, 32'hBEEF_0000, 4'b1100);
    step();
    checks++; if (haddr !== 32'h0000_0206) begin errors++; $display("FAIL t2_haddr got=%h exp=206", haddr); end
    checks++; if (hsize !== 3'b001) begin errors++; $display("FAIL t2_hsize got=%b exp=001", hsize); end
    step();
    checks++; if (hwstrb !== 4'b1100) begin errors++; $display("FAIL t2_hwstrb got=%b exp=1100", hwstrb); end
    checks++; if (hwdata !== 32'hBEEF_0000) begin errors++; $display("FAIL t2_hwdata got=%h exp=beef0000", hwdata); end
    step();
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL t2_empty got=%b exp=1", sb_empty); end
  endtask

  task automatic test_full_and_drain();
    logic [31:0] addrs [4];
    logic [31:0] datas [4];
    addrs = '{32'h400, 32'h404, 32'h408, 32'h40C};
    datas = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    hready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (st_stall !== 1'b0) begin errors++; $display("FAIL t3_stall_early k=%0d got=%b exp=0", k, st_stall); end
      enqueue(addrs[k], datas[k], 4'b1111);
    end
    checks++; if (st_stall !== 1'b1) begin errors++; $display("FAIL t3_stall_full got=%b exp=1", st_stall); end
    enqueue(32'h500, 32'hDEAD_DEAD, 4'b1111);
    checks++; if (st_stall !== 1'b1) begin errors++; $display("FAIL t3_stall_hold got=%b exp=1", st_stall); end
    checks++; if ({htrans, haddr} !== {2'b10, addrs[0]}) begin errors++; $display("FAIL t3_addr0 got=%h/%h exp=2/400", htrans, haddr); end
    checks++; if (hsize !== 3'b010) begin errors++; $display("FAIL t3_hsize got=%b exp=010", hsize); end
    hready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if ({htrans, hwdata} !== {2'b00, datas[k]}) begin errors++; $display("FAIL t3_data k=%0d got=%h/%h exp=0/%h", k, htrans, hwdata, datas[k]); end
      if (k == 0) begin
        checks++; if (st_stall !== 1'b1) begin errors++; $display("FAIL t3_stall_prepop got=%b exp=1", st_stall); end
      end
      step();
      if (k < 3) begin
        checks++; if ({htrans, haddr} !== {2'b10, addrs[k+1]}) begin errors++; $display("FAIL t3_addr k=%0d got=%h/%h exp=2/%h", k+1, htrans, haddr, addrs[k+1]); end
      end else begin
        checks++; if ({sb_empty, htrans} !== 3'b100) begin errors++; $display("FAIL t3_drained got=%b exp=100", {sb_empty, htrans}); end
      end
      if (k == 0) begin
        checks++; if (st_stall !== 1'b0) begin errors++; $display("FAIL t3_stall_drop got=%b exp=0", st_stall); end
      end
    end
  endtask

  task automatic test_error_resp();
    enqueue(32'h600, 32'hAAAA_0600, 4'b1111);
    enqueue(32'h604, 32'hBBBB_0604, 4'b1111);
    step();
    checks++; if (hwdata !== 32'hAAAA_0600) begin errors++; $display("FAIL t4_dataA got=%h exp=aaaa0600", hwdata); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL t4_err_pre got=%b exp=0", sb_err); end
    hresp = 1'b1;
    step();
    hresp = 1'b0;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL t4_err_set got=%b exp=1", sb_err); end
    checks++; if ({htrans, haddr} !== {2'b10, 32'h604}) begin errors++; $display("FAIL t4_addrB got=%h/%h exp=2/604", htrans, haddr); end
    step();
    checks++; if (hwdata !== 32'hBBBB_0604) begin errors++; $display("FAIL t4_dataB got=%h exp=bbbb0604", hwdata); end
    step();
    checks++; if ({sb_err, sb_empty} !== 2'b11) begin errors++; $display("FAIL t4_sticky got=%b exp=11", {sb_err, sb_empty}); end
  endtask

  task automatic test_reset_mid();
    hready = 1'b0;
    enqueue(32'h700, 32'h7000_0000, 4'b1111);
    enqueue(32'h704, 32'h7000_0004, 4'b1111);
    enqueue(32'h708, 32'h7000_0008, 4'b1111);
    hready = 1'b1;
    step();
    hready = 1'b0;
    checks++; if ({htrans, hwdata} !== {2'b00, 32'h7000_0000}) begin errors++; $display("FAIL t5_in_data got=%h/%h exp=0/70000000", htrans, hwdata); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({htrans, sb_empty, sb_err, st_stall} !== 5'b00100) begin errors++; $display("FAIL t5_after_rst got=%b exp=00100", {htrans, sb_empty, sb_err, st_stall}); end
    hready = 1'b1;
    step(); step();
    checks++; if ({htrans, sb_empty} !== 3'b001) begin errors++; $display("FAIL t5_discarded got=%b exp=001", {htrans, sb_empty}); end
  endtask

  task automatic test_load_hazard();
    hready = 1'b0;
    ld_addr = 32'h302;
    enqueue(32'h300, 32'h3000_0000, 4'b1111);
    #1;
    checks++; if (ld_hazard !== HAZ_EXP) begin errors++; $display("FAIL t6_hit_queued got=%b exp=%b", ld_hazard, HAZ_EXP); end
    ld_addr = 32'h304;
    #1;
    checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL t6_miss got=%b exp=0", ld_hazard); end
    ld_addr = 32'h302;
    step();
    hready = 1'b1;
    step();
    checks++; if (ld_hazard !== HAZ_EXP) begin errors++; $display("FAIL t6_hit_inflight got=%b exp=%b", ld_hazard, HAZ_EXP); end
    step();
    checks++; if ({ld_hazard, sb_empty} !== 2'b01) begin errors++; $display("FAIL t6_after_pop got=%b exp=01", {ld_hazard, sb_empty}); end
  endtask

  initial begin
    test_reset();
    test_mask_zero();
    test_single_byte();
    test_halfword();
    test_full_and_drain();
    test_error_resp();
    test_reset_mid();
    test_load_hazard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
